// File: rtl/ecb_dec.sv
// ecb_dec: iterative AES-128 ECB decryption core (FIPS-197 inverse cipher).
// One round per clock. A key-cache miss first runs the key schedule forward
// to rk10 (10 cycles), then performs the 10 inverse rounds while walking the
// schedule backwards. A hit on the last-key cache skips the forward walk.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start_i        request, accepted only while busy_o is low
//   ciphertext_i   128-bit input block, sampled at the accept edge
//   key_i          128-bit cipher key, sampled at the accept edge
//   plaintext_o    decrypted block, registered, held until the next done
//   busy_o         high from the accept edge until the done edge
//   done_o         one-cycle pulse, plaintext_o valid in that cycle
module ecb_dec #(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] ciphertext_i,
  input  logic [127:0] key_i,
  output logic [127:0] plaintext_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, KEXP = 2'd1, ROUND = 2'd2} fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Undo the affine map first, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] fwd_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Words 3..1 are recovered first; word 0 needs the recovered word 3
  function automatic logic [127:0] inv_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[31:0]  ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  // Row r of column c is byte 4c+r; row r rotates right by r
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  fsm_e         fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] st_q, wk_q, ct_q;
  logic [127:0] rk_fwd_d, rk_inv_d, ark_d, round_d;
  logic         cache_hit_s;
  logic [127:0] cache_rk_s;

  // In KEXP wk_q holds rk_{cnt-1}; in ROUND it holds rk_{cnt+1}
  assign rk_fwd_d = fwd_key(wk_q, rcon(cnt_q));
  assign rk_inv_d = inv_key(wk_q, rcon(cnt_q + 4'd1));
  assign ark_d    = inv_shift_sub(st_q) ^ rk_inv_d;
  assign round_d  = inv_mix_columns(ark_d);

  generate
    if (KEY_CACHE) begin : g_cache
      logic [127:0] pend_key_q, cache_key_q, cache_rk_q;
      logic         cache_vld_q;
      logic         accept_s, cache_wr_s;

      assign accept_s   = (fsm_q == IDLE) && start_i;
      assign cache_wr_s = (fsm_q == KEXP) && (cnt_q == 4'd10);

      // Keep the accepted key until rk10 exists, then store the pair
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_key_q  <= 128'h0;
          cache_key_q <= 128'h0;
          cache_rk_q  <= 128'h0;
          cache_vld_q <= 1'b0;
        end else begin
          if (accept_s) begin
            pend_key_q <= key_i;
          end
          if (cache_wr_s) begin
            cache_key_q <= pend_key_q;
            cache_rk_q  <= rk_fwd_d;
            cache_vld_q <= 1'b1;
          end
        end
      end

      assign cache_hit_s = cache_vld_q && (cache_key_q == key_i);
      assign cache_rk_s  = cache_rk_q;
    end else begin : g_nocache
      assign cache_hit_s = 1'b0;
      assign cache_rk_s  = 128'h0;
    end
  endgenerate

  // Control FSM with the round datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      cnt_q       <= 4'd0;
      st_q        <= 128'h0;
      wk_q        <= 128'h0;
      ct_q        <= 128'h0;
      plaintext_o <= 128'h0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            busy_o <= 1'b1;
            ct_q   <= ciphertext_i;
            if (cache_hit_s) begin
              st_q  <= ciphertext_i ^ cache_rk_s;
              wk_q  <= cache_rk_s;
              cnt_q <= 4'd9;
              fsm_q <= ROUND;
            end else begin
              wk_q  <= key_i;
              cnt_q <= 4'd1;
              fsm_q <= KEXP;
            end
          end
        end
        KEXP: begin
          wk_q <= rk_fwd_d;
          if (cnt_q == 4'd10) begin
            st_q  <= ct_q ^ rk_fwd_d;
            cnt_q <= 4'd9;
            fsm_q <= ROUND;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          wk_q <= rk_inv_d;
          if (cnt_q == 4'd0) begin
            plaintext_o <= ark_d;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            fsm_q       <= IDLE;
          end else begin
            st_q  <= round_d;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          fsm_q  <= IDLE;
          cnt_q  <= 4'd0;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecb_dec.sv
// Self-checking bench for ecb_dec: FIPS-197 vectors, cache hit/miss latency,
// back-to-back streaming, reset abort, a KEY_CACHE=0 build and random blocks
// checked against an independent AES-128 encryption model.
module tb_ecb_dec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start0, start1;
  logic [127:0] ct_i, key_i;
  logic [127:0] pt0, pt1;
  logic         busy0, busy1, done0, done1;

  ecb_dec #(.KEY_CACHE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .ciphertext_i(ct_i), .key_i(key_i),
    .plaintext_o(pt0), .busy_o(busy0), .done_o(done0)
  );

  ecb_dec #(.KEY_CACHE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .ciphertext_i(ct_i), .key_i(key_i),
    .plaintext_o(pt1), .busy_o(busy1), .done_o(done1)
  );

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    bit           has_pt;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  logic [7:0]   sbox_t [256];
  int           tests = 0;
  int           fails = 0;
  int           sel = 0;
  bit           mvld = 1'b0;
  logic [127:0] mkey = 128'h0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  // Classic generator: walk p by powers of 3 and q by powers of 1/3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c+j] = t[4*((c+j)%4)+j];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called #1 after a clock edge; leaves the bench #1 after the done edge.
  // noise=1 keeps start high and scrambles ct/key while the core is busy.
  task automatic do_block(input logic [127:0] ct, input logic [127:0] key,
                          input logic [127:0] pt, input bit has_pt, input bit noise);
    exp_t e, got;
    int   lat;
    bit   busy_ok;
    e.ct = ct; e.key = key; e.pt = pt; e.has_pt = has_pt;
    if (sel == 1) e.lat = 20;
    else if (mvld && key == mkey) e.lat = 10;
    else begin
      e.lat = 20;
      mvld  = 1'b1;
      mkey  = key;
    end
    sb_q.push_back(e);
    ct_i = ct;
    key_i = key;
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    if (!noise) begin
      start0 = 1'b0;
      start1 = 1'b0;
    end
    busy_ok = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (!(sel == 1 ? busy1 : busy0)) busy_ok = 1'b0;
      if (noise) begin
        ct_i = rand128();
        key_i = rand128();
      end
      @(posedge clk); #1;
      if (sel == 1 ? done1 : done0) lat = i;
    end
    got = sb_q.pop_front();
    check("busy_while_running", busy_ok, 1'b1);
    check("busy_at_done", sel == 1 ? busy1 : busy0, 1'b0);
    check("latency", lat, got.lat);
    if (got.has_pt) check("plaintext", sel == 1 ? pt1 : pt0, got.pt);
    else check("reencrypt", aes_enc(sel == 1 ? pt1 : pt0, got.key), got.ct);
  endtask

  logic [127:0] k, p;
  bit           quiet;

  initial begin
    build_sbox();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ct_i = 128'h0; key_i = 128'h0;
    #1;
    check("reset_plaintext", pt0, 128'h0);
    check("reset_busy", busy0, 1'b0);
    check("reset_done", done0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Known vectors, miss then hit, then alternating keys
    do_block(C1_CT, C1_KEY, C1_PT, 1'b1, 1'b0);
    do_block(B_CT, B_KEY, B_PT, 1'b1, 1'b0);
    do_block(B_CT, B_KEY, B_PT, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      do_block(C1_CT, C1_KEY, C1_PT, 1'b1, 1'b0);
      do_block(B_CT, B_KEY, B_PT, 1'b1, 1'b0);
    end

    // Streaming with start held high and junk inputs during busy
    k = rand128();
    for (int i = 0; i < 4; i++) begin
      p = rand128();
      do_block(aes_enc(p, k), k, p, 1'b1, 1'b1);
    end
    start0 = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0 || busy0) quiet = 1'b0;
    end
    check("no_extra_done", quiet, 1'b1);

    // Reset in the middle of a cache-hit decryption
    do_block(C1_CT, C1_KEY, C1_PT, 1'b1, 1'b0);
    ct_i = C1_CT; key_i = C1_KEY; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_plaintext", pt0, 128'h0);
    check("abort_busy", busy0, 1'b0);
    check("abort_done", done0, 1'b0);
    mvld = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    do_block(C1_CT, C1_KEY, C1_PT, 1'b1, 1'b0);

    // Build without the cache always takes the long path
    sel = 1;
    do_block(C1_CT, C1_KEY, C1_PT, 1'b1, 1'b0);
    do_block(B_CT, B_KEY, B_PT, 1'b1, 1'b0);
    do_block(B_CT, B_KEY, B_PT, 1'b1, 1'b1);
    do_block(B_CT, B_KEY, B_PT, 1'b1, 1'b1);
    start1 = 1'b0;
    @(posedge clk); #1;
    sel = 0;

    // Extreme keys and ciphertexts, checked by re-encrypting the result
    do_block(128'h0, 128'h0, 128'h0, 1'b0, 1'b0);
    do_block({128{1'b1}}, 128'h0, 128'h0, 1'b0, 1'b0);
    do_block({128{1'b1}}, {128{1'b1}}, 128'h0, 1'b0, 1'b0);
    do_block(128'h0, {128{1'b1}}, 128'h0, 1'b0, 1'b0);

    // Random blocks; every fourth reuses the previous key
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 != 3) k = rand128();
      p = rand128();
      do_block(aes_enc(p, k), k, p, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
